// File: rtl/sysid_check_ctrl.sv
// Boot-time SysID checker: reads ID and build timestamp, retries on mismatch or timeout,
// and reports through a 4-word status slave. Define SYSID_CHECK_IRQ_EN for the completion irq.
module sysid_check_ctrl #(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'd1616605598,
    parameter int          START_DELAY    = 16,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          MAX_RETRIES    = 3
) (
    input  logic        clock,
    input  logic        reset,
    output logic        m_address,
    output logic        m_read,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,
    input  logic        m_readdatavalid,
    input  logic [1:0]  s_address,
    input  logic        s_read,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic        done,
    output logic        pass,
    output logic        irq
);
    typedef enum logic [2:0] {DELAY, RD_ID, WAIT_ID, RD_TS, WAIT_TS, EVAL, DONE} state_t;

    localparam logic [7:0] DELAY_LAST = 8'(START_DELAY - 1);
    localparam logic [9:0] TMO_LAST   = 10'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] RETRY_MAX  = 4'(MAX_RETRIES);

    state_t      state;
    logic [7:0]  delay_cnt;
    logic [9:0]  tmo_cnt;
    logic [3:0]  retries;
    logic [31:0] id_reg;
    logic [31:0] ts_reg;
    logic        timeout_err;
    logic        id_mismatch;
    logic        ts_mismatch;
    logic        irq_en;
    logic        ctrl_write;
    logic        restart;
    logic        tmo_hit;
    logic        unused_ok;

    assign ctrl_write = s_write && (s_address == 2'd3);
    assign restart    = ctrl_write && s_writedata[0];
    assign tmo_hit    = (tmo_cnt == TMO_LAST);
    assign unused_ok  = ^{s_read, s_writedata[31:1]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= DELAY;
            delay_cnt   <= '0;
            tmo_cnt     <= '0;
            retries     <= '0;
            id_reg      <= '0;
            ts_reg      <= '0;
            timeout_err <= 1'b0;
            id_mismatch <= 1'b0;
            ts_mismatch <= 1'b0;
            m_read      <= 1'b0;
            m_address   <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
        end else if (restart) begin
            // Abandon whatever is in flight; late read data lands in DELAY and is dropped.
            state       <= DELAY;
            delay_cnt   <= '0;
            tmo_cnt     <= '0;
            retries     <= '0;
            id_reg      <= '0;
            ts_reg      <= '0;
            timeout_err <= 1'b0;
            id_mismatch <= 1'b0;
            ts_mismatch <= 1'b0;
            m_read      <= 1'b0;
            m_address   <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
        end else begin
            case (state)
                DELAY: begin
                    if (delay_cnt == DELAY_LAST) begin
                        delay_cnt   <= '0;
                        tmo_cnt     <= '0;
                        timeout_err <= 1'b0;
                        m_read      <= 1'b1;
                        m_address   <= 1'b0;
                        state       <= RD_ID;
                    end else begin
                        delay_cnt <= delay_cnt + 8'd1;
                    end
                end
                RD_ID: begin
                    // Data arriving in the cycle that completes the count still wins.
                    if (!m_waitrequest && m_readdatavalid) begin
                        id_reg    <= m_readdata;
                        m_address <= 1'b1;
                        tmo_cnt   <= '0;
                        state     <= RD_TS;
                    end else if (tmo_hit) begin
                        m_read      <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= EVAL;
                    end else begin
                        tmo_cnt <= tmo_cnt + 10'd1;
                        if (!m_waitrequest) begin
                            m_read <= 1'b0;
                            state  <= WAIT_ID;
                        end
                    end
                end
                WAIT_ID: begin
                    if (m_readdatavalid) begin
                        id_reg    <= m_readdata;
                        m_read    <= 1'b1;
                        m_address <= 1'b1;
                        tmo_cnt   <= '0;
                        state     <= RD_TS;
                    end else if (tmo_hit) begin
                        timeout_err <= 1'b1;
                        state       <= EVAL;
                    end else begin
                        tmo_cnt <= tmo_cnt + 10'd1;
                    end
                end
                RD_TS: begin
                    if (!m_waitrequest && m_readdatavalid) begin
                        ts_reg <= m_readdata;
                        m_read <= 1'b0;
                        state  <= EVAL;
                    end else if (tmo_hit) begin
                        m_read      <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= EVAL;
                    end else begin
                        tmo_cnt <= tmo_cnt + 10'd1;
                        if (!m_waitrequest) begin
                            m_read <= 1'b0;
                            state  <= WAIT_TS;
                        end
                    end
                end
                WAIT_TS: begin
                    if (m_readdatavalid) begin
                        ts_reg <= m_readdata;
                        state  <= EVAL;
                    end else if (tmo_hit) begin
                        timeout_err <= 1'b1;
                        state       <= EVAL;
                    end else begin
                        tmo_cnt <= tmo_cnt + 10'd1;
                    end
                end
                EVAL: begin
                    // A timed-out attempt reports only timeout_err, not stale compare results.
                    id_mismatch <= !timeout_err && (id_reg != EXPECTED_ID);
                    ts_mismatch <= !timeout_err && (ts_reg != EXPECTED_TS);
                    if (!timeout_err && (id_reg == EXPECTED_ID) && (ts_reg == EXPECTED_TS)) begin
                        pass  <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (retries < RETRY_MAX) begin
                        retries <= retries + 4'd1;
                        state   <= DELAY;
                    end else begin
                        pass  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= DONE;
            endcase
        end
    end

`ifdef SYSID_CHECK_IRQ_EN
    logic done_prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irq_en    <= 1'b0;
            irq       <= 1'b0;
            done_prev <= 1'b0;
        end else begin
            done_prev <= done;
            if (ctrl_write) begin
                irq_en <= s_writedata[1];
            end
            if (restart || (ctrl_write && s_writedata[2])) begin
                irq <= 1'b0;
            end else if (done && !done_prev && irq_en) begin
                irq <= 1'b1;
            end
        end
    end
`else
    assign irq_en = 1'b0;
    assign irq    = 1'b0;
`endif

    always_comb begin
        s_readdata = '0;
        case (s_address)
            2'd0:    s_readdata = {20'd0, retries, 3'd0, ts_mismatch, id_mismatch, timeout_err, pass, done};
            2'd1:    s_readdata = id_reg;
            2'd2:    s_readdata = ts_reg;
            default: s_readdata = {30'd0, irq_en, 1'b0};
        endcase
    end
endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Randomized bench for sysid_check_ctrl: a behavioural SysID slave plus an attempt-level outcome model.
`timescale 1ns/1ps
module tb_sysid_check_ctrl;
    localparam logic [31:0] EXP_ID = 32'h0000_0000;
    localparam logic [31:0] EXP_TS = 32'd1616605598;
    localparam int S    = 16;
    localparam int T    = 24;
    localparam int MAXR = 3;
`ifdef SYSID_CHECK_IRQ_EN
    localparam bit IRQ_BUILD = 1'b1;
`else
    localparam bit IRQ_BUILD = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        m_address;
    logic        m_read;
    logic        m_waitrequest;
    logic [31:0] m_readdata;
    logic        m_readdatavalid;
    logic [1:0]  s_address = 2'd0;
    logic        s_read = 1'b0;
    logic        s_write = 1'b0;
    logic [31:0] s_writedata = 32'd0;
    logic [31:0] s_readdata;
    logic        done;
    logic        pass;
    logic        irq;

    always #5 clock = ~clock;

    sysid_check_ctrl #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS),
        .START_DELAY(S), .TIMEOUT_CYCLES(T), .MAX_RETRIES(MAXR)
    ) dut (
        .clock(clock), .reset(reset),
        .m_address(m_address), .m_read(m_read), .m_waitrequest(m_waitrequest),
        .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_readdata(s_readdata),
        .done(done), .pass(pass), .irq(irq)
    );

    int checks = 0;
    int errors = 0;

    // Per-attempt slave behaviour, indexed by attempt number relative to cfg_base.
    int          cfg_stall  [16][2];
    int          cfg_lat    [16][2];
    bit          cfg_noresp [16][2];
    logic [31:0] cfg_data   [16][2];
    int          cfg_base = 0;

    // Slave-owned bookkeeping.
    int          attempt_seen = 0;
    int          cur_idx = 0;
    bit          in_req = 0;
    logic        req_addr = 1'b0;
    int          stall_left = 0;
    int          run_len = 0;
    int          run_len_w [2];
    bit          addr_bad = 0;
    bit          pending = 0;
    int          pend_cnt = 0;
    logic [31:0] pend_data = 32'd0;
    logic        pend_addr = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    initial begin : slave
        m_waitrequest = 1'b0;
        m_readdatavalid = 1'b0;
        m_readdata = 32'd0;
        forever begin
            @(posedge clock); #1;
            m_readdatavalid = 1'b0;
            m_waitrequest = 1'b0;
            if (reset) begin
                in_req = 0;
                pending = 0;
            end else begin
                if (pending) begin
                    pend_cnt--;
                    if (pend_cnt == 0) begin
                        m_readdatavalid = 1'b1;
                        m_readdata = pend_data;
                        pending = 0;
                    end
                end
                if (!m_read) begin
                    if (in_req) begin
                        run_len_w[req_addr] = run_len;
                        in_req = 0;
                    end
                end else begin
                    if (!in_req) begin
                        in_req = 1;
                        req_addr = m_address;
                        run_len = 0;
                        if (!m_address) begin
                            cur_idx = attempt_seen - cfg_base;
                            if (cur_idx > 15) cur_idx = 15;
                            if (cur_idx < 0) cur_idx = 0;
                            attempt_seen++;
                        end
                        stall_left = cfg_stall[cur_idx][req_addr];
                    end
                    if (m_address != req_addr) addr_bad = 1;
                    run_len++;
                    if (stall_left > 0) begin
                        m_waitrequest = 1'b1;
                        stall_left--;
                    end else begin
                        run_len_w[req_addr] = run_len;
                        in_req = 0;
                        if (!cfg_noresp[cur_idx][req_addr]) begin
                            if (cfg_lat[cur_idx][req_addr] == 0) begin
                                m_readdatavalid = 1'b1;
                                m_readdata = cfg_data[cur_idx][req_addr];
                            end else begin
                                pending = 1;
                                pend_cnt = cfg_lat[cur_idx][req_addr];
                                pend_data = cfg_data[cur_idx][req_addr];
                                pend_addr = req_addr;
                            end
                        end
                    end
                end
            end
        end
    end

    function automatic bit word_ok(input int k, input int w);
        return !cfg_noresp[k][w] && (cfg_stall[k][w] + cfg_lat[k][w] + 1 <= T);
    endfunction

    // Outcome of a whole check sequence from the per-attempt slave behaviour.
    task automatic model(input int first, output logic [31:0] st, output logic [31:0] id,
                         output logic [31:0] ts, output int attempts);
        int r;
        bit tmo, idm, tsm, good;
        id = 32'd0; ts = 32'd0; r = 0;
        tmo = 0; idm = 0; tsm = 0; good = 0;
        for (int k = first; k < first + MAXR + 1; k++) begin
            tmo = !word_ok(k, 0);
            if (!tmo) begin
                id = cfg_data[k][0];
                tmo = !word_ok(k, 1);
                if (!tmo) ts = cfg_data[k][1];
            end
            idm  = !tmo && (id != EXP_ID);
            tsm  = !tmo && (ts != EXP_TS);
            good = !tmo && !idm && !tsm;
            if (good || r == MAXR) break;
            r++;
        end
        attempts = r + 1;
        st = (32'(r) << 8) | (32'(tsm) << 4) | (32'(idm) << 3) | (32'(tmo) << 2) | (32'(good) << 1) | 32'd1;
    endtask

    task automatic set_all_good();
        for (int k = 0; k < 16; k++) begin
            for (int w = 0; w < 2; w++) begin
                cfg_stall[k][w] = 0;
                cfg_lat[k][w] = 1;
                cfg_noresp[k][w] = 0;
            end
            cfg_data[k][0] = EXP_ID;
            cfg_data[k][1] = EXP_TS;
        end
    endtask

    task automatic set_random();
        int r;
        for (int k = 0; k < 16; k++) begin
            for (int w = 0; w < 2; w++) begin
                r = int'($urandom_range(0, 9));
                cfg_noresp[k][w] = (r == 0);
                cfg_stall[k][w] = (r == 1) ? int'($urandom_range(T - 2, T + 3)) : int'($urandom_range(0, 3));
                cfg_lat[k][w] = (r == 2) ? int'($urandom_range(4, 8)) : int'($urandom_range(0, 3));
            end
            cfg_data[k][0] = ($urandom_range(0, 3) == 0) ? (EXP_ID ^ (32'd1 << $urandom_range(0, 31))) : EXP_ID;
            cfg_data[k][1] = ($urandom_range(0, 3) == 0) ? (EXP_TS ^ (32'd1 << $urandom_range(0, 31))) : EXP_TS;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] v);
        @(posedge clock); #1;
        s_address = a; s_writedata = v; s_write = 1'b1;
        @(posedge clock); #1;
        s_write = 1'b0; s_writedata = 32'd0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        s_address = a;
        #1;
        d = s_readdata;
    endtask

    task automatic restart_seq(input string tag, input logic [31:0] ctrl);
        logic [31:0] d;
        bus_write(2'd3, ctrl);
        bus_read(2'd0, d); check_val({tag, "/clr_status"}, d, 32'd0);
        bus_read(2'd2, d); check_val({tag, "/clr_ts"}, d, 32'd0);
        bus_read(2'd3, d); check_val({tag, "/ctrl_rd"}, d, {30'd0, IRQ_BUILD, 1'b0});
        check_val({tag, "/clr_irq"}, 32'(irq), 32'd0);
    endtask

    task automatic wait_done(input string tag, output bit ok);
        ok = 0;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clock); #1;
            if (done) begin
                ok = 1;
                break;
            end
        end
        check_val({tag, "/done_seen"}, 32'(ok), 32'd1);
    endtask

    task automatic check_final(input string tag, input logic [31:0] st, input logic [31:0] id,
                               input logic [31:0] ts, input int att);
        logic [31:0] d;
        bus_read(2'd0, d); check_val({tag, "/status"}, d, st);
        $display("run %s: status=0x%03h attempts=%0d", tag, d, attempt_seen - cfg_base);
        bus_read(2'd1, d); check_val({tag, "/id"}, d, id);
        bus_read(2'd2, d); check_val({tag, "/ts"}, d, ts);
        check_val({tag, "/pass"}, 32'(pass), 32'(st[1]));
        check_val({tag, "/mread_done"}, 32'(m_read), 32'd0);
        check_val({tag, "/attempts"}, 32'(attempt_seen - cfg_base), 32'(att));
    endtask

    task automatic run(input string tag, input logic [31:0] ctrl, output logic [31:0] st);
        logic [31:0] id, ts;
        int att;
        bit ok;
        cfg_base = attempt_seen;
        restart_seq(tag, ctrl);
        wait_done(tag, ok);
        if (ok) begin
            check_val({tag, "/irq_at_done"}, 32'(irq), 32'd0);
            @(posedge clock); #1;
            check_val({tag, "/irq_after"}, 32'(irq), 32'(IRQ_BUILD));
        end
        model(0, st, id, ts, att);
        check_final(tag, st, id, ts, att);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] d, st, id, ts;
        int n, first_mr, first_done, att;
        bit ok;

        // Power-on: reset values, then the default sequence with its latencies.
        set_all_good();
        repeat (3) @(posedge clock);
        #1;
        check_val("rst/m_read", 32'(m_read), 32'd0);
        check_val("rst/m_address", 32'(m_address), 32'd0);
        check_val("rst/done", 32'(done), 32'd0);
        check_val("rst/pass", 32'(pass), 32'd0);
        check_val("rst/irq", 32'(irq), 32'd0);
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), d);
            check_val($sformatf("rst/word%0d", a), d, 32'd0);
        end
        reset = 1'b0;
        n = 0; first_mr = -1; first_done = -1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clock); #1;
            n++;
            if (m_read && first_mr < 0) first_mr = n;
            if (done) begin
                first_done = n;
                break;
            end
        end
        // m_read is high during cycle START_DELAY+1, i.e. after edge START_DELAY.
        check_val("boot/first_mread", 32'(first_mr), 32'(S));
        check_val("boot/done_lat", 32'(first_done - first_mr), 32'd5);
        @(posedge clock); #1;
        check_val("boot/irq_disabled", 32'(irq), 32'd0);
        bus_read(2'd0, d); check_val("boot/status", d, 32'h003);
        bus_read(2'd2, d); check_val("boot/ts", d, EXP_TS);
        check_val("boot/pass", 32'(pass), 32'd1);

        // Timestamp wrong on every attempt.
        set_all_good();
        for (int k = 0; k < 16; k++) cfg_data[k][1] = EXP_TS + 32'd1;
        run("ts_bad", 32'h3, st);
        check_val("ts_bad/status_const", st, 32'h311);

        // No read data ever returned.
        set_all_good();
        for (int k = 0; k < 16; k++) cfg_noresp[k][0] = 1;
        run("no_valid", 32'h3, st);
        check_val("no_valid/status_const", st, 32'h305);

        // Waitrequest stuck high: m_read must drop after exactly T cycles.
        set_all_good();
        for (int k = 0; k < 16; k++) cfg_stall[k][0] = 1000;
        run("stuck", 32'h3, st);
        check_val("stuck/hold_len", 32'(run_len_w[0]), 32'(T));

        // 20-cycle stall on the first read, within the timeout.
        set_all_good();
        cfg_stall[0][0] = 20;
        run("stall20", 32'h3, st);
        check_val("stall20/hold_len", 32'(run_len_w[0]), 32'd21);
        check_val("stall20/addr_stable", 32'(addr_bad), 32'd0);
        check_val("stall20/status_const", st, 32'h003);

        // Interrupt clear, then restart combined with clear.
        bus_write(2'd3, 32'h6);
        check_val("irq_clr/irq", 32'(irq), 32'd0);
        set_all_good();
        run("rst_clr", 32'h7, st);

        // Restart while waiting on the timestamp; its late data lands in DELAY.
        set_all_good();
        cfg_lat[0][1] = 10;
        cfg_data[0][1] = 32'hDEAD_BEEF;
        cfg_base = attempt_seen;
        restart_seq("stale", 32'h3);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clock); #1;
            if (pending && pend_addr) begin
                ok = 1;
                break;
            end
        end
        check_val("stale/ts_issued", 32'(ok), 32'd1);
        restart_seq("stale_rs", 32'h3);
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            if (!pending) break;
        end
        @(posedge clock); #1;
        bus_read(2'd2, d); check_val("stale/ts_ignored", d, 32'd0);
        check_val("stale/in_delay", 32'(m_read), 32'd0);
        wait_done("stale", ok);
        model(1, st, id, ts, att);
        check_final("stale", st, id, ts, att + 1);

        // Randomized slave behaviour.
        for (int it = 0; it < 12; it++) begin
            set_random();
            run($sformatf("rand%0d", it), 32'h3, st);
        end

        // Asynchronous reset in the middle of a stalled read.
        set_all_good();
        for (int k = 0; k < 16; k++) cfg_stall[k][0] = 1000;
        cfg_base = attempt_seen;
        restart_seq("areset", 32'h3);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock); #1;
            if (m_read) begin
                ok = 1;
                break;
            end
        end
        check_val("areset/mread_up", 32'(ok), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_val("areset/mread_drop", 32'(m_read), 32'd0);
        bus_read(2'd3, d); check_val("areset/ctrl", d, 32'd0);
        #10;
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
